// File: rtl/ysyx_22050019_axi_sram.sv
// ysyx_22050019_axi_sram: AXI4-Lite responder backed by a word-addressed 64-bit array.
// Independent read (AR/R) and write (AW/W/B) state machines; read latency set by RD_LAT.
// Optional build macro YSYX_22050019_AXI_SRAM_BP_EN adds LFSR-driven backpressure on
// ar_ready, aw_ready and w_ready.
module ysyx_22050019_axi_sram #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 1024,
   parameter logic [63:0] BASE   = 64'h8000_0000,
   parameter int unsigned RD_LAT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_axi_ar_valid,
   output logic                  s_axi_ar_ready,
   input  logic [ADDR_W-1:0]     s_axi_ar_addr,
   output logic                  s_axi_r_valid,
   input  logic                  s_axi_r_ready,
   output logic [DATA_W-1:0]     s_axi_r_data,
   output logic [1:0]            s_axi_r_resp,
   input  logic                  s_axi_aw_valid,
   output logic                  s_axi_aw_ready,
   input  logic [ADDR_W-1:0]     s_axi_aw_addr,
   input  logic                  s_axi_w_valid,
   output logic                  s_axi_w_ready,
   input  logic [DATA_W-1:0]     s_axi_w_data,
   input  logic [DATA_W/8-1:0]   s_axi_w_strb,
   output logic                  s_axi_b_valid,
   input  logic                  s_axi_b_ready,
   output logic [1:0]            s_axi_b_resp
);

   localparam int unsigned       IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned       STRB_W      = DATA_W / 8;
   localparam logic [ADDR_W-1:0] BASE_A      = ADDR_W'(BASE);
   localparam logic [ADDR_W-1:0] DEPTH_A     = ADDR_W'(DEPTH);
   localparam logic [3:0]        LAT         = 4'(RD_LAT);
   localparam logic [1:0]        RESP_OKAY   = 2'b00;
   localparam logic [1:0]        RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rd_state_t;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;

   logic [DATA_W-1:0] mem [DEPTH];

   rd_state_t         r_state, r_state_nxt;
   wr_state_t         w_state, w_state_nxt;
   logic [3:0]        r_cnt, r_cnt_nxt;
   logic [IDX_W-1:0]  r_idx, w_idx;
   logic              r_ok, w_ok;
   logic              bp_ok;

   // Address decode for both address channels
   logic [ADDR_W-1:0] ar_off, aw_off;
   logic [IDX_W-1:0]  ar_idx, aw_idx;
   logic              ar_ok, aw_ok;

   assign ar_off = s_axi_ar_addr - BASE_A;
   assign aw_off = s_axi_aw_addr - BASE_A;
   assign ar_ok  = (s_axi_ar_addr >= BASE_A) && ((ar_off >> 3) < DEPTH_A);
   assign aw_ok  = (s_axi_aw_addr >= BASE_A) && ((aw_off >> 3) < DEPTH_A);
   assign ar_idx = IDX_W'(ar_off >> 3);
   assign aw_idx = IDX_W'(aw_off >> 3);

   logic ar_fire, r_fire, aw_fire, w_fire, b_fire;
   assign ar_fire = s_axi_ar_valid & s_axi_ar_ready;
   assign r_fire  = s_axi_r_valid  & s_axi_r_ready;
   assign aw_fire = s_axi_aw_valid & s_axi_aw_ready;
   assign w_fire  = s_axi_w_valid  & s_axi_w_ready;
   assign b_fire  = s_axi_b_valid  & s_axi_b_ready;

`ifdef YSYX_22050019_AXI_SRAM_BP_EN
   logic [7:0] lfsr, lfsr_nxt;
   assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   // Ready registers load lfsr_nxt[0] so the visible ready equals state & lfsr[0]
   assign bp_ok = lfsr_nxt[0];

   // Free-running backpressure LFSR
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lfsr <= 8'hA5;
      else      lfsr <= lfsr_nxt;
   end
`else
   assign bp_ok = 1'b1;
`endif

   // Read FSM next-state and latency counter
   always_comb begin
      r_state_nxt = r_state;
      r_cnt_nxt   = r_cnt;
      case (r_state)
         R_IDLE: begin
            if (ar_fire) begin
               r_cnt_nxt   = LAT;
               r_state_nxt = (LAT == 4'd0) ? R_RESP : R_WAIT;
            end
         end
         R_WAIT: begin
            if (r_cnt <= 4'd1) r_state_nxt = R_RESP;
            else               r_cnt_nxt   = r_cnt - 4'd1;
         end
         R_RESP: begin
            if (r_fire) r_state_nxt = R_IDLE;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // Read data is captured on the edge that enters R_RESP; with zero latency
   // that is the AR handshake edge, so the live decode is used instead of the latch
   logic             r_cap, cap_ok;
   logic [IDX_W-1:0] cap_idx;
   assign r_cap   = (r_state_nxt == R_RESP) && (r_state != R_RESP);
   assign cap_ok  = (r_state == R_IDLE) ? ar_ok  : r_ok;
   assign cap_idx = (r_state == R_IDLE) ? ar_idx : r_idx;

   // Read state register and registered read-channel outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= R_IDLE;
         r_cnt          <= 4'd0;
         r_idx          <= '0;
         r_ok           <= 1'b0;
         s_axi_ar_ready <= 1'b0;
         s_axi_r_valid  <= 1'b0;
         s_axi_r_data   <= '0;
         s_axi_r_resp   <= RESP_OKAY;
      end else begin
         r_state        <= r_state_nxt;
         r_cnt          <= r_cnt_nxt;
         s_axi_ar_ready <= (r_state_nxt == R_IDLE) & bp_ok;
         s_axi_r_valid  <= (r_state_nxt == R_RESP);
         if (ar_fire) begin
            r_idx <= ar_idx;
            r_ok  <= ar_ok;
         end
         if (r_cap) begin
            s_axi_r_data <= cap_ok ? mem[cap_idx] : '0;
            s_axi_r_resp <= cap_ok ? RESP_OKAY : RESP_DECERR;
         end
      end
   end

   // Write FSM next-state
   always_comb begin
      w_state_nxt = w_state;
      case (w_state)
         W_IDLE:  if (aw_fire) w_state_nxt = W_DATA;
         W_DATA:  if (w_fire)  w_state_nxt = W_RESP;
         W_RESP:  if (b_fire)  w_state_nxt = W_IDLE;
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // Write state register and registered write-channel outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_state        <= W_IDLE;
         w_idx          <= '0;
         w_ok           <= 1'b0;
         s_axi_aw_ready <= 1'b0;
         s_axi_w_ready  <= 1'b0;
         s_axi_b_valid  <= 1'b0;
         s_axi_b_resp   <= RESP_OKAY;
      end else begin
         w_state        <= w_state_nxt;
         s_axi_aw_ready <= (w_state_nxt == W_IDLE) & bp_ok;
         s_axi_w_ready  <= (w_state_nxt == W_DATA) & bp_ok;
         s_axi_b_valid  <= (w_state_nxt == W_RESP);
         if (aw_fire) begin
            w_idx <= aw_idx;
            w_ok  <= aw_ok;
         end
         if (w_fire) s_axi_b_resp <= w_ok ? RESP_OKAY : RESP_DECERR;
      end
   end

   // Byte-lane array update; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (w_fire && w_ok) begin
         for (int unsigned i = 0; i < STRB_W; i++) begin
            if (s_axi_w_strb[i]) mem[w_idx][i*8 +: 8] <= s_axi_w_data[i*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22050019_axi_sram.sv
// Scoreboard bench for ysyx_22050019_axi_sram (default build, no backpressure).
module tb_ysyx_22050019_axi_sram;

   localparam int unsigned RD_LAT = 2;
   localparam int unsigned DEPTH  = 1024;
   localparam logic [63:0] BASE   = 64'h8000_0000;
   localparam int          TMO    = 100;

   logic        clk, rst;
   logic        s_axi_ar_valid, s_axi_ar_ready;
   logic [63:0] s_axi_ar_addr;
   logic        s_axi_r_valid, s_axi_r_ready;
   logic [63:0] s_axi_r_data;
   logic [1:0]  s_axi_r_resp;
   logic        s_axi_aw_valid, s_axi_aw_ready;
   logic [63:0] s_axi_aw_addr;
   logic        s_axi_w_valid, s_axi_w_ready;
   logic [63:0] s_axi_w_data;
   logic [7:0]  s_axi_w_strb;
   logic        s_axi_b_valid, s_axi_b_ready;
   logic [1:0]  s_axi_b_resp;

   ysyx_22050019_axi_sram #(
      .ADDR_W(64), .DATA_W(64), .DEPTH(DEPTH), .BASE(BASE), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axi_ar_valid(s_axi_ar_valid), .s_axi_ar_ready(s_axi_ar_ready), .s_axi_ar_addr(s_axi_ar_addr),
      .s_axi_r_valid(s_axi_r_valid), .s_axi_r_ready(s_axi_r_ready),
      .s_axi_r_data(s_axi_r_data), .s_axi_r_resp(s_axi_r_resp),
      .s_axi_aw_valid(s_axi_aw_valid), .s_axi_aw_ready(s_axi_aw_ready), .s_axi_aw_addr(s_axi_aw_addr),
      .s_axi_w_valid(s_axi_w_valid), .s_axi_w_ready(s_axi_w_ready),
      .s_axi_w_data(s_axi_w_data), .s_axi_w_strb(s_axi_w_strb),
      .s_axi_b_valid(s_axi_b_valid), .s_axi_b_ready(s_axi_b_ready), .s_axi_b_resp(s_axi_b_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   logic [65:0] rd_q [$];   // {resp, data}
   logic [1:0]  wr_q [$];
   logic [63:0] model [int unsigned];
   logic [63:0] pend_aw;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic in_range(input logic [63:0] a);
      return (a >= BASE) && (((a - BASE) >> 3) < 64'(DEPTH));
   endfunction

   function automatic int unsigned idx_of(input logic [63:0] a);
      return 32'((a - BASE) >> 3);
   endfunction

   function automatic logic [65:0] exp_rd(input logic [63:0] a);
      if (!in_range(a)) return {2'b11, 64'h0};
      if (model.exists(idx_of(a))) return {2'b00, model[idx_of(a)]};
      return {2'b00, 64'h0};
   endfunction

   task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
      logic [63:0] w;
      if (!in_range(a)) return;
      w = model.exists(idx_of(a)) ? model[idx_of(a)] : 64'h0;
      for (int i = 0; i < 8; i++) if (s[i]) w[i*8 +: 8] = d[i*8 +: 8];
      model[idx_of(a)] = w;
   endtask

   // All tasks start and end on a falling edge; t is the handshake cycle index
   task automatic ar_req(input logic [63:0] a, output int t);
      int n = 0;
      s_axi_ar_valid = 1'b1;
      s_axi_ar_addr  = a;
      while (!s_axi_ar_ready && n < TMO) begin @(negedge clk); n++; end
      check("ar_ready_wait", 64'(s_axi_ar_ready), 64'd1);
      t = cyc;
      rd_q.push_back(exp_rd(a));
      @(negedge clk);
      s_axi_ar_valid = 1'b0;
   endtask

   task automatic r_wait(input int t_ar);
      int n = 0;
      while (!s_axi_r_valid && n < TMO) begin @(negedge clk); n++; end
      check("r_valid_wait", 64'(s_axi_r_valid), 64'd1);
      check("r_latency", 64'(cyc - t_ar), 64'(RD_LAT + 1));
   endtask

   task automatic r_take();
      logic [65:0] e;
      check("rd_q_size", 64'(rd_q.size()), 64'd1);
      e = (rd_q.size() > 0) ? rd_q.pop_front() : 66'h0;
      check("r_data", s_axi_r_data, e[63:0]);
      check("r_resp", 64'(s_axi_r_resp), 64'(e[65:64]));
      s_axi_r_ready = 1'b1;
      @(negedge clk);
      s_axi_r_ready = 1'b0;
      check("r_valid_clear", 64'(s_axi_r_valid), 64'd0);
      check("ar_ready_after_r", 64'(s_axi_ar_ready), 64'd1);
   endtask

   task automatic aw_req(input logic [63:0] a);
      int n = 0;
      s_axi_aw_valid = 1'b1;
      s_axi_aw_addr  = a;
      while (!s_axi_aw_ready && n < TMO) begin @(negedge clk); n++; end
      check("aw_ready_wait", 64'(s_axi_aw_ready), 64'd1);
      wr_q.push_back(in_range(a) ? 2'b00 : 2'b11);
      pend_aw = a;
      @(negedge clk);
      s_axi_aw_valid = 1'b0;
      check("w_ready_after_aw", 64'(s_axi_w_ready), 64'd1);
   endtask

   task automatic w_send(input logic [63:0] d, input logic [7:0] s);
      int n = 0;
      logic [1:0] e;
      s_axi_w_valid = 1'b1;
      s_axi_w_data  = d;
      s_axi_w_strb  = s;
      while (!s_axi_w_ready && n < TMO) begin @(negedge clk); n++; end
      check("w_ready_wait", 64'(s_axi_w_ready), 64'd1);
      @(negedge clk);
      s_axi_w_valid = 1'b0;
      model_write(pend_aw, d, s);
      check("b_valid", 64'(s_axi_b_valid), 64'd1);
      e = (wr_q.size() > 0) ? wr_q.pop_front() : 2'bxx;
      check("b_resp", 64'(s_axi_b_resp), 64'(e));
      s_axi_b_ready = 1'b1;
      @(negedge clk);
      s_axi_b_ready = 1'b0;
      check("b_valid_clear", 64'(s_axi_b_valid), 64'd0);
      check("aw_ready_after_b", 64'(s_axi_aw_ready), 64'd1);
   endtask

   task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
      aw_req(a);
      w_send(d, s);
   endtask

   task automatic do_read(input logic [63:0] a);
      int t;
      ar_req(a, t);
      r_wait(t);
      r_take();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ar_ready"}, 64'(s_axi_ar_ready), 64'd0);
      check({tag, "_aw_ready"}, 64'(s_axi_aw_ready), 64'd0);
      check({tag, "_w_ready"},  64'(s_axi_w_ready),  64'd0);
      check({tag, "_r_valid"},  64'(s_axi_r_valid),  64'd0);
      check({tag, "_b_valid"},  64'(s_axi_b_valid),  64'd0);
      check({tag, "_r_data"},   s_axi_r_data,        64'd0);
      check({tag, "_r_resp"},   64'(s_axi_r_resp),   64'd0);
      check({tag, "_b_resp"},   64'(s_axi_b_resp),   64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   localparam logic [63:0] A0  = 64'h8000_0010;
   localparam logic [63:0] OOR = BASE + 64'(DEPTH) * 64'd8;

   initial begin
      int t;
      s_axi_ar_valid = 0; s_axi_ar_addr = 0; s_axi_r_ready = 0;
      s_axi_aw_valid = 0; s_axi_aw_addr = 0; s_axi_w_valid = 0;
      s_axi_w_data = 0; s_axi_w_strb = 0; s_axi_b_ready = 0; pend_aw = 0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      @(negedge clk);
      check("rel_ar_ready", 64'(s_axi_ar_ready), 64'd1);
      check("rel_aw_ready", 64'(s_axi_aw_ready), 64'd1);

      // Full write then read back
      do_write(A0, 64'h1122_3344_5566_7788, 8'hFF);
      do_read(A0);

      // Partial write over low half
      do_write(A0, 64'hFFFF_FFFF_AAAA_BBBB, 8'h0F);
      check("model_partial", model[idx_of(A0)], 64'h1122_3344_AAAA_BBBB);
      do_read(A0);

      // Out-of-range reads and write; word 0 must not alias the OOR write
      do_write(BASE, 64'h0123_4567_89AB_CDEF, 8'hFF);
      do_read(64'h7FFF_FFF8);
      do_read(OOR);
      do_write(OOR, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
      do_read(BASE);

      // Random full then partial writes with read-back
      for (int i = 0; i < 4; i++) begin
         logic [63:0] a, d1, d2;
         a  = BASE + 64'($urandom_range(2, DEPTH - 1)) * 64'd8 + 64'($urandom_range(0, 7));
         d1 = {$urandom, $urandom};
         d2 = {$urandom, $urandom};
         do_write(a, d1, 8'hFF);
         do_write(a, d2, 8'($urandom_range(0, 255)));
         do_read(a);
      end

      // Hold r_ready low: response and ar_ready must stay put
      ar_req(A0, t);
      r_wait(t);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_r_valid", 64'(s_axi_r_valid), 64'd1);
         check("hold_r_data", s_axi_r_data, 64'h1122_3344_AAAA_BBBB);
         check("hold_ar_ready", 64'(s_axi_ar_ready), 64'd0);
      end
      r_take();

      // W commit on the same edge as read capture: old data, then new
      aw_req(A0);
      ar_req(A0, t);
      @(negedge clk);
      check("conc_r_valid_early", 64'(s_axi_r_valid), 64'd0);
      w_send(64'h5A5A_5A5A_5A5A_5A5A, 8'hFF);
      check("conc_r_valid", 64'(s_axi_r_valid), 64'd1);
      check("conc_r_data_old", s_axi_r_data, 64'h1122_3344_AAAA_BBBB);
      r_take();
      do_read(A0);

      // Reset during R_WAIT and W_DATA: pending write must be dropped
      aw_req(A0);
      ar_req(BASE, t);
      #1 rst = 1'b0;
      s_axi_w_valid = 1'b1;
      s_axi_w_data  = 64'hBAD0_BAD0_BAD0_BAD0;
      s_axi_w_strb  = 8'hFF;
      #1 check_all_zero("midrst");
      @(negedge clk);
      @(negedge clk);
      s_axi_w_valid = 1'b0;
      rd_q.delete();
      wr_q.delete();
      rst = 1'b1;
      @(negedge clk);
      check("rst2_ar_ready", 64'(s_axi_ar_ready), 64'd1);
      check("rst2_aw_ready", 64'(s_axi_aw_ready), 64'd1);
      check("rst2_w_ready", 64'(s_axi_w_ready), 64'd0);
      do_read(A0);
      do_read(BASE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
